// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the mem_ctrl packet buffer between NPORTS writers and NPORTS readers.
// One beat in flight at a time; packets stay atomic per class, round-robin within each class.
//
//   state   | meaning
//   IDLE    | choose next beat (write/read alternate when both eligible)
//   W_ISSUE | mc_write and wr_gnt pulse for the chosen input port
//   W_WAIT  | wait for mc_done, watchdog running
//   R_ISSUE | mc_read pulse for the chosen output port
//   R_WAIT  | wait for mc_pushout, watchdog running
module mem_arbiter #(
  parameter int NPORTS  = 4,
  parameter int PORT_W  = 5,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        wr_req,
  input  logic [NPORTS-1:0]        wr_first,
  input  logic [NPORTS-1:0]        wr_last,
  input  logic [NPORTS*DATA_W-1:0] wr_data,
  input  logic [NPORTS*PORT_W-1:0] wr_dst,
  output logic [NPORTS-1:0]        wr_gnt,
  input  logic [NPORTS-1:0]        rd_req,
  output logic [NPORTS-1:0]        rd_valid,
  output logic                     rd_last,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     mc_write,
  output logic                     mc_read,
  output logic                     mc_firstin,
  output logic                     mc_lastin,
  output logic [PORT_W-1:0]        mc_port_in,
  output logic [PORT_W-1:0]        mc_port_out,
  output logic [DATA_W-1:0]        mc_writedata,
  input  logic                     mc_done,
  input  logic                     mc_pushout,
  input  logic                     mc_lastout,
  input  logic [DATA_W-1:0]        mc_readdata,
  input  logic                     mc_memory_full,
  input  logic                     mc_write_stop,
  input  logic                     mc_read_stop,
  output logic                     arb_err
);

  localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic CLS_WR = 1'b0;
  localparam logic CLS_RD = 1'b1;
  localparam logic [7:0] WD_LOAD = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, W_ISSUE, W_WAIT, R_ISSUE, R_WAIT} state_t;
  state_t state, next_state;

  logic [IDX_W-1:0] wr_ptr, rd_ptr, wr_lock_port, rd_lock_port, cur_port;
  logic             wr_lock_vld, rd_lock_vld, last_class, cur_last;
  logic [7:0]       wdog;
  logic             wdog_tc;

  logic             w_elig, r_elig;
  logic [IDX_W-1:0] w_sel, r_sel, w_cand, r_cand;
  logic             issue_w, issue_r, w_done, r_done, wd_abort;

  function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(NPORTS-1)) ? '0 : p + IDX_W'(1);
  endfunction

  assign wdog_tc = (wdog == 8'd1);

  // Write candidate: the locked port continues its packet, otherwise round-robin over first beats.
  always_comb begin
    w_elig = 1'b0;
    w_sel  = wr_ptr;
    w_cand = wr_ptr;
    if (wr_lock_vld) begin
      w_sel  = wr_lock_port;
      w_elig = wr_req[wr_lock_port] && !mc_write_stop;
    end else if (!mc_memory_full && !mc_write_stop) begin
      for (int i = 0; i < NPORTS; i++) begin
        w_cand = IDX_W'((int'(wr_ptr) + i) % NPORTS);
        if (!w_elig && wr_req[w_cand] && wr_first[w_cand]) begin
          w_elig = 1'b1;
          w_sel  = w_cand;
        end
      end
    end
  end

  always_comb begin
    r_elig = 1'b0;
    r_sel  = rd_ptr;
    r_cand = rd_ptr;
    if (!mc_read_stop) begin
      if (rd_lock_vld) begin
        r_sel  = rd_lock_port;
        r_elig = rd_req[rd_lock_port];
      end else begin
        for (int i = 0; i < NPORTS; i++) begin
          r_cand = IDX_W'((int'(rd_ptr) + i) % NPORTS);
          if (!r_elig && rd_req[r_cand]) begin
            r_elig = 1'b1;
            r_sel  = r_cand;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    issue_w    = 1'b0;
    issue_r    = 1'b0;
    w_done     = 1'b0;
    r_done     = 1'b0;
    wd_abort   = 1'b0;
    case (state)
      IDLE: begin
        if (w_elig && (!r_elig || last_class == CLS_RD)) begin
          issue_w    = 1'b1;
          next_state = W_ISSUE;
        end else if (r_elig) begin
          issue_r    = 1'b1;
          next_state = R_ISSUE;
        end
      end
      W_ISSUE: next_state = W_WAIT;
      R_ISSUE: next_state = R_WAIT;
      W_WAIT: begin
        if (mc_done) begin
          w_done     = 1'b1;
          next_state = IDLE;
        end else if (wdog_tc) begin
          wd_abort   = 1'b1;
          next_state = IDLE;
        end
      end
      R_WAIT: begin
        if (mc_pushout) begin
          r_done     = 1'b1;
          next_state = IDLE;
        end else if (wdog_tc) begin
          wd_abort   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_gnt       <= '0;
      rd_valid     <= '0;
      rd_last      <= 1'b0;
      rd_data      <= '0;
      mc_write     <= 1'b0;
      mc_read      <= 1'b0;
      mc_firstin   <= 1'b0;
      mc_lastin    <= 1'b0;
      mc_port_in   <= '0;
      mc_port_out  <= '0;
      mc_writedata <= '0;
      arb_err      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wr_lock_vld  <= 1'b0;
      wr_lock_port <= '0;
      rd_lock_vld  <= 1'b0;
      rd_lock_port <= '0;
      cur_port     <= '0;
      cur_last     <= 1'b0;
      last_class   <= CLS_RD;
      wdog         <= '0;
    end else begin
      wr_gnt   <= '0;
      rd_valid <= '0;
      rd_last  <= 1'b0;
      mc_write <= 1'b0;
      mc_read  <= 1'b0;
      arb_err  <= 1'b0;

      if (issue_w) begin
        mc_write      <= 1'b1;
        wr_gnt[w_sel] <= 1'b1;
        mc_firstin    <= wr_first[w_sel];
        mc_lastin     <= wr_last[w_sel];
        mc_port_in    <= PORT_W'(w_sel);
        mc_port_out   <= wr_dst[w_sel*PORT_W +: PORT_W];
        mc_writedata  <= wr_data[w_sel*DATA_W +: DATA_W];
        cur_port      <= w_sel;
        cur_last      <= wr_last[w_sel];
        last_class    <= CLS_WR;
        wdog          <= WD_LOAD;
        if (wr_first[w_sel]) begin
          wr_lock_vld  <= 1'b1;
          wr_lock_port <= w_sel;
        end
      end else if (issue_r) begin
        mc_read      <= 1'b1;
        mc_port_out  <= PORT_W'(r_sel);
        cur_port     <= r_sel;
        rd_lock_vld  <= 1'b1;
        rd_lock_port <= r_sel;
        last_class   <= CLS_RD;
        wdog         <= WD_LOAD;
      end else if (w_done) begin
        wdog <= '0;
        if (cur_last) begin
          wr_lock_vld <= 1'b0;
          wr_ptr      <= next_port(cur_port);
        end
      end else if (r_done) begin
        wdog                   <= '0;
        rd_valid[rd_lock_port] <= 1'b1;
        rd_last                <= mc_lastout;
        rd_data                <= mc_readdata;
        if (mc_lastout) begin
          rd_lock_vld <= 1'b0;
          rd_ptr      <= next_port(rd_lock_port);
        end
      end else if (wd_abort) begin
        // Hung beat: drop the waiting class's packet so other ports are not starved.
        arb_err <= 1'b1;
        wdog    <= '0;
        if (state == W_WAIT) begin
          wr_lock_vld <= 1'b0;
          wr_ptr      <= next_port(cur_port);
        end else begin
          rd_lock_vld <= 1'b0;
          rd_ptr      <= next_port(cur_port);
        end
      end else if (state == W_WAIT || state == R_WAIT) begin
        wdog <= wdog - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small mem_ctrl responder and per-port packet sources,
// with expected values worked out by hand for each scenario.
module tb_mem_arbiter;
  localparam int NP = 4;
  localparam int PW = 5;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset;
  logic [NP-1:0]    wr_req, wr_first, wr_last, wr_gnt, rd_req, rd_valid;
  logic [NP*DW-1:0] wr_data;
  logic [NP*PW-1:0] wr_dst;
  logic             rd_last;
  logic [DW-1:0]    rd_data;
  logic             mc_write, mc_read, mc_firstin, mc_lastin;
  logic [PW-1:0]    mc_port_in, mc_port_out;
  logic [DW-1:0]    mc_writedata;
  logic             mc_done, mc_pushout, mc_lastout;
  logic [DW-1:0]    mc_readdata;
  logic             mc_memory_full, mc_write_stop, mc_read_stop, arb_err;

  mem_arbiter #(.NPORTS(NP), .PORT_W(PW), .DATA_W(DW), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_first(wr_first), .wr_last(wr_last), .wr_data(wr_data),
    .wr_dst(wr_dst), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_last(rd_last), .rd_data(rd_data),
    .mc_write(mc_write), .mc_read(mc_read), .mc_firstin(mc_firstin), .mc_lastin(mc_lastin),
    .mc_port_in(mc_port_in), .mc_port_out(mc_port_out), .mc_writedata(mc_writedata),
    .mc_done(mc_done), .mc_pushout(mc_pushout), .mc_lastout(mc_lastout),
    .mc_readdata(mc_readdata), .mc_memory_full(mc_memory_full),
    .mc_write_stop(mc_write_stop), .mc_read_stop(mc_read_stop), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          src_len[NP], src_idx[NP];
  logic [DW-1:0] src_base[NP];
  logic [PW-1:0] src_dst[NP];
  bit          auto_w, auto_r, pend_w, pend_r;
  int          rd_len, rd_cnt;
  int          n_wr, n_rd, n_err, gnt_bad;
  int          gnt_cnt[NP], rv_cnt[NP];
  int          wl_port[$], wl_dst[$], wl_cyc[$], rl_port[$];
  int          wl_first[$], wl_last[$], rv_last[$];
  logic [DW-1:0] wl_data[$], rv_data[$];
  int          cls[$];
  int          rd_cyc, err_cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic outs_any();
    return (|wr_gnt) | (|rd_valid) | rd_last | (|rd_data) | mc_write | mc_read |
           mc_firstin | mc_lastin | (|mc_port_in) | (|mc_port_out) | (|mc_writedata) | arb_err;
  endfunction

  task automatic apply_src();
    for (int p = 0; p < NP; p++) begin
      wr_req[p]           = (src_idx[p] < src_len[p]);
      wr_first[p]         = (src_idx[p] == 0);
      wr_last[p]          = (src_idx[p] == src_len[p] - 1);
      wr_data[p*DW +: DW] = src_base[p] + 64'(src_idx[p]);
      wr_dst[p*PW +: PW]  = src_dst[p];
    end
  endtask

  // One clock: sample DUT outputs, play mem_ctrl (completion one cycle after the command), update sources.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mc_done    = 1'b0;
    mc_pushout = 1'b0;
    mc_lastout = 1'b0;
    if (pend_w) begin
      mc_done = 1'b1;
      pend_w  = 1'b0;
    end
    if (pend_r) begin
      mc_readdata = 64'hD0 + 64'(rd_cnt);
      rd_cnt++;
      mc_pushout = 1'b1;
      mc_lastout = (rd_cnt == rd_len);
      if (rd_cnt == rd_len) rd_cnt = 0;
      pend_r = 1'b0;
    end
    if (mc_write) begin
      n_wr++;
      wl_port.push_back(int'(mc_port_in));
      wl_dst.push_back(int'(mc_port_out));
      wl_first.push_back(int'(mc_firstin));
      wl_last.push_back(int'(mc_lastin));
      wl_data.push_back(mc_writedata);
      wl_cyc.push_back(cyc);
      cls.push_back(0);
      if (wr_gnt != (NP'(1) << mc_port_in)) gnt_bad++;
      if (auto_w) pend_w = 1'b1;
    end
    if (mc_read) begin
      n_rd++;
      rl_port.push_back(int'(mc_port_out));
      cls.push_back(1);
      rd_cyc = cyc;
      if (auto_r) pend_r = 1'b1;
    end
    if (arb_err) begin
      n_err++;
      err_cyc = cyc;
    end
    for (int p = 0; p < NP; p++) begin
      if (wr_gnt[p]) begin
        gnt_cnt[p]++;
        src_idx[p]++;
      end
      if (rd_valid[p]) begin
        rv_cnt[p]++;
        rv_data.push_back(rd_data);
        rv_last.push_back(int'(rd_last));
        if (rd_last) rd_req[p] = 1'b0;
      end
    end
    apply_src();
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    auto_w = 1'b1; auto_r = 1'b1; pend_w = 1'b0; pend_r = 1'b0;
    rd_len = 1; rd_cnt = 0;
    mc_done = 1'b0; mc_pushout = 1'b0; mc_lastout = 1'b0; mc_readdata = '0;
    mc_memory_full = 1'b0; mc_write_stop = 1'b0; mc_read_stop = 1'b0;
    rd_req = '0;
    for (int p = 0; p < NP; p++) begin
      src_len[p] = 0; src_idx[p] = 0; src_base[p] = '0; src_dst[p] = '0;
      gnt_cnt[p] = 0; rv_cnt[p] = 0;
    end
    n_wr = 0; n_rd = 0; n_err = 0; gnt_bad = 0;
    wl_port.delete(); wl_dst.delete(); wl_cyc.delete(); rl_port.delete();
    wl_first.delete(); wl_last.delete(); rv_last.delete();
    wl_data.delete(); rv_data.delete(); cls.delete();
    apply_src();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_wr(input string tag, input int target, input int budget);
    for (int k = 0; k < budget && n_wr < target; k++) tick();
    chk(tag, 64'(n_wr >= target), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    reset_dut();
    chk("rst_outs", 64'(outs_any()), 64'd0);
    chk("rst_wr_ptr", 64'(dut.wr_ptr), 64'd0);
    chk("rst_last_class", 64'(dut.last_class), 64'd1);

    // 1: three-beat packet on port 2
    src_len[2] = 3; src_base[2] = 64'hA0; src_dst[2] = 5'd1;
    apply_src();
    wait_wr("t1_wait", 3, 60);
    run(4);
    chk("t1_nwr", 64'(n_wr), 64'd3);
    chk("t1_first", 64'(wl_first[0]*100 + wl_first[1]*10 + wl_first[2]), 64'd100);
    chk("t1_last", 64'(wl_last[0]*100 + wl_last[1]*10 + wl_last[2]), 64'd1);
    chk("t1_port", 64'(wl_port[0]*100 + wl_port[1]*10 + wl_port[2]), 64'd222);
    chk("t1_dst", 64'(wl_dst[2]), 64'd1);
    chk("t1_d0", wl_data[0], 64'hA0);
    chk("t1_d2", wl_data[2], 64'hA2);
    chk("t1_period", 64'(wl_cyc[1] - wl_cyc[0]), 64'd3);
    chk("t1_gnt", 64'(gnt_cnt[2]), 64'd3);
    chk("t1_gnt_align", 64'(gnt_bad), 64'd0);
    chk("t1_wr_ptr", 64'(dut.wr_ptr), 64'd3);

    // 2: ports 0 and 3 compete from wr_ptr=0; packet atomicity and pointer wrap
    reset_dut();
    src_len[0] = 2; src_base[0] = 64'hB0; src_dst[0] = 5'd3;
    src_len[3] = 2; src_base[3] = 64'hC0; src_dst[3] = 5'd2;
    apply_src();
    wait_wr("t2_wait", 4, 80);
    run(4);
    chk("t2_order", 64'(wl_port[0]*1000 + wl_port[1]*100 + wl_port[2]*10 + wl_port[3]), 64'd33);
    chk("t2_d2", wl_data[2], 64'hC0);
    chk("t2_wr_ptr", 64'(dut.wr_ptr), 64'd0);

    // 3: write on port 1 and read on port 0 alternate, write first
    reset_dut();
    src_len[1] = 2; src_base[1] = 64'hE0; src_dst[1] = 5'd0;
    rd_len = 2; rd_req[0] = 1'b1;
    apply_src();
    for (int k = 0; k < 80 && !(n_wr >= 2 && rv_cnt[0] >= 2); k++) tick();
    run(3);
    chk("t3_done", 64'(n_wr * 10 + rv_cnt[0]), 64'd22);
    chk("t3_alt", 64'(cls[0]*1000 + cls[1]*100 + cls[2]*10 + cls[3]), 64'd101);
    chk("t3_rport", 64'(rl_port[0]), 64'd0);
    chk("t3_rdata0", rv_data[0], 64'hD0);
    chk("t3_rdata1", rv_data[1], 64'hD1);
    chk("t3_rlast", 64'(rv_last[0]*10 + rv_last[1]), 64'd1);
    chk("t3_rd_ptr", 64'(dut.rd_ptr), 64'd1);

    // 4: memory full blocks new packets but not a locked continuation
    reset_dut();
    src_len[1] = 3; src_base[1] = 64'hF0;
    apply_src();
    wait_wr("t4_start", 1, 20);
    mc_memory_full = 1'b1;
    src_len[0] = 1; src_base[0] = 64'h90;
    apply_src();
    wait_wr("t4_cont", 3, 40);
    run(20);
    chk("t4_blocked", 64'(n_wr), 64'd3);
    chk("t4_port1", 64'(wl_port[0]*100 + wl_port[1]*10 + wl_port[2]), 64'd111);
    mc_memory_full = 1'b0;
    wait_wr("t4_resume", 4, 20);
    chk("t4_port0", 64'(wl_port[3]*10 + wl_first[3]), 64'd1);
    chk("t4_data0", wl_data[3], 64'h90);

    // 5: read never returns, watchdog aborts
    reset_dut();
    auto_r = 1'b0;
    rd_req[2] = 1'b1;
    for (int k = 0; k < 20 && n_rd < 1; k++) tick();
    rd_req[2] = 1'b0;
    chk("t5_read", 64'(n_rd), 64'd1);
    for (int k = 0; k < 400 && n_err < 1; k++) tick();
    chk("t5_err_seen", 64'(n_err), 64'd1);
    chk("t5_err_delay", 64'(err_cyc - rd_cyc), 64'd256);
    run(3);
    chk("t5_err_pulse", 64'(n_err), 64'd1);
    chk("t5_rd_lock", 64'(dut.rd_lock_vld), 64'd0);
    chk("t5_rd_ptr", 64'(dut.rd_ptr), 64'd3);
    chk("t5_no_rvalid", 64'(rv_cnt[2]), 64'd0);
    src_len[0] = 1; src_base[0] = 64'h77;
    apply_src();
    wait_wr("t5_idle", 1, 10);

    // 6: reset pulse during W_WAIT, late mc_done, next packet from port 0
    reset_dut();
    auto_w = 1'b0;
    src_len[2] = 2; src_base[2] = 64'h50;
    apply_src();
    wait_wr("t6_start", 1, 20);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_rst_outs", 64'(outs_any()), 64'd0);
    reset = 1'b1;
    mc_done = 1'b1;
    src_idx[2] = 0;
    src_len[0] = 1; src_base[0] = 64'h60;
    apply_src();
    auto_w = 1'b1;
    wait_wr("t6_next", 2, 20);
    chk("t6_port0", 64'(wl_port[1]), 64'd0);
    chk("t6_gnt2", 64'(gnt_cnt[2]), 64'd1);
    chk("t6_data", wl_data[1], 64'h60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
